// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and decode helpers for the multiply/divide unit
package muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as two's complement
  function automatic logic op_a_signed(muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as two's complement
  function automatic logic op_b_signed(muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - unsigned restoring divider, one quotient bit per cycle
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [XLEN:0]    r_sh;
  logic [XLEN:0]    diff;
  logic             fits;

  // One restoring step; quotient/remainder expose the post-step values so the
  // caller can capture the final answer on the same edge as the last step.
  always_comb begin
    r_sh      = {rem_q, quo_q[XLEN-1]};
    diff      = r_sh - {1'b0, dvs_q};
    fits      = !diff[XLEN];
    quotient  = {quo_q[XLEN-2:0], fits};
    remainder = fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    done      = running && (cnt == LAST);
  end

  // Load on start, then shift/subtract for exactly XLEN steps
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem_q   <= '0;
      quo_q   <= dividend;
      dvs_q   <= divisor;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem_q <= remainder;
      quo_q <= quotient;
      if (cnt == LAST) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV M-extension multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  input  logic             flush,
  output logic             busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state, state_nxt;
  muldiv_op_t      op_in, op_q;
  logic            accept;
  logic            legal_in, a_neg_in, b_neg_in;
  logic            div_zero_in, div_ovf_in, special_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;
  logic            a_neg_q, sgn_diff_q;
  logic            div_start, div_clear, div_done, mul_last;
  logic [XLEN-1:0] quo_raw, rem_raw, div_res, mul_res;

  assign op_in     = muldiv_op_t'(funct3);
  assign in_ready  = (state == ST_IDLE) && !flush && !reset;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Decode the offered op: magnitudes for the iterative paths, and the
  // cases that finish immediately (illegal, divide by zero, overflow)
  always_comb begin
    legal_in    = (funct7 == MULDIV_FUNCT7);
    a_neg_in    = op_a_signed(op_in) && op_a[XLEN-1];
    b_neg_in    = op_b_signed(op_in) && op_b[XLEN-1];
    a_mag_in    = a_neg_in ? -op_a : op_a;
    b_mag_in    = b_neg_in ? -op_b : op_b;
    div_zero_in = (op_b == '0);
    div_ovf_in  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (op_a == MOST_NEG) && (op_b == '1);
    special_in  = !legal_in || (op_is_div(op_in) && (div_zero_in || div_ovf_in));
    special_res = '0;
    if (legal_in && div_zero_in) begin
      special_res = op_is_rem(op_in) ? op_a : '1;
    end else if (legal_in && div_ovf_in) begin
      special_res = op_is_rem(op_in) ? '0 : op_a;
    end
  end

  assign div_start = accept && !special_in && op_is_div(op_in);
  assign div_clear = reset || flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over everything else
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (special_in)             state_nxt = ST_DONE;
            else if (op_is_div(op_in))  state_nxt = ST_DIV;
            else                        state_nxt = ST_MUL;
          end
        end
        ST_MUL:  if (mul_last)  state_nxt = ST_DONE;
        ST_DIV:  if (div_done)  state_nxt = ST_DONE;
        ST_DONE: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Op and sign bookkeeping captured at accept, used for result sign fix-up
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_MUL;
      a_neg_q    <= 1'b0;
      sgn_diff_q <= 1'b0;
    end else if (accept) begin
      op_q       <= op_in;
      a_neg_q    <= a_neg_in;
      sgn_diff_q <= a_neg_in ^ b_neg_in;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0]   op_a_q, op_b_q;
  logic [2*XLEN+1:0] a_ext, b_ext, prod;

  assign mul_last = 1'b1;

  // Raw operands for the single-cycle multiplier
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      op_a_q <= op_a;
      op_b_q <= op_b;
    end
  end

  // Full 2*XLEN+2 product of sign- or zero-extended operands
  always_comb begin
    a_ext   = {{(XLEN+2){op_a_signed(op_q) && op_a_q[XLEN-1]}}, op_a_q};
    b_ext   = {{(XLEN+2){op_b_signed(op_q) && op_b_q[XLEN-1]}}, op_b_q};
    prod    = a_ext * b_ext;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
`else
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_nxt, prod;
  logic [XLEN-1:0]   mplier;

  assign mul_last = (cnt == LAST);

  // One shift-add step on magnitudes, then restore the product sign
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
    prod    = sgn_diff_q ? -acc_nxt : acc_nxt;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Shift-add multiplier registers and iteration counter
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, a_mag_in};
      mplier <= b_mag_in;
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= mul_last ? '0 : cnt + CNT_W'(1);
    end
  end
`endif

  muldiv_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk       (clk),
    .reset     (div_clear),
    .start     (div_start),
    .dividend  (a_mag_in),
    .divisor   (b_mag_in),
    .quotient  (quo_raw),
    .remainder (rem_raw),
    .done      (div_done)
  );

  // Quotient takes the xor of operand signs, remainder the dividend sign
  always_comb begin
    if (op_is_rem(op_q)) begin
      div_res = a_neg_q ? -rem_raw : rem_raw;
    end else begin
      div_res = sgn_diff_q ? -quo_raw : quo_raw;
    end
  end

  // Result/tag/illegal capture; held steady for the whole DONE state
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      out_tag <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      out_tag <= in_tag;
      illegal <= !legal_in;
      if (special_in) begin
        result <= special_res;
      end
    end else if (!flush && (state == ST_MUL) && mul_last) begin
      result <= mul_res;
    end else if (!flush && (state == ST_DIV) && div_done) begin
      result <= div_res;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL take parameter TAG_W, default 5, giving the width of the destination-register tag carried alongside each operation.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation offered.
REQ-006 The block SHALL have port in_ready, output, 1, operation accepted this cycle when in_valid is also high.
REQ-007 The block SHALL have ports funct7 (input, 7) and funct3 (input, 3), the instruction fields selecting the operation.
REQ-008 The block SHALL have ports op_a and op_b, input, XLEN, the rs1 and rs2 values.
REQ-009 The block SHALL have port in_tag, input, TAG_W, the destination tag.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), result (output, XLEN), out_tag (output, TAG_W) and illegal (output, 1).
REQ-011 The block SHALL have port flush, input, 1, which aborts any in-flight operation.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with flush low; an accept is in_valid & in_ready.
REQ-015 On accept, operands, tag and decoded op SHALL be registered.
REQ-016 funct3 SHALL decode as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-017 funct7 other than 7'b0000001 SHALL go directly to DONE with result 0 and illegal 1.
REQ-018 MUL ops SHALL go to MUL. MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-019 DIV ops SHALL go to DIV and iterate a restoring divider for exactly XLEN cycles, one quotient bit per cycle, on magnitudes; the result sign is fixed afterwards for DIV and REM.
REQ-020 Divide by zero SHALL skip DIV and go to DONE in 1 cycle, with quotient all ones and remainder op_a.
REQ-021 Signed overflow (op_a = most negative, op_b = -1) SHALL go to DONE in 1 cycle, with quotient op_a and remainder 0.
REQ-022 In DONE, out_valid SHALL be 1; result, out_tag and illegal SHALL stay stable until out_ready, then the state returns to IDLE.
REQ-023 No new accept SHALL occur in the cycle DONE is left.
REQ-024 flush SHALL return the state to IDLE at the next edge from any state, discarding any result; a result that is already completing in that cycle is also dropped.
REQ-025 flush SHALL have priority over in_valid and out_ready.
REQ-026 The iteration counter SHALL be $clog2(XLEN)+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-027 While reset is high: state IDLE, out_valid 0, result 0, out_tag 0, illegal 0, busy 0, counter 0, in_ready 0.
REQ-028 Reset mid-operation SHALL discard all operation state with no output.

Configuration
REQ-029 With MULDIV_FAST_MUL_EN defined, MUL SHALL last one cycle: a full-width 2*XLEN+2-bit product, so an accept at edge N gives out_valid after edge N+2.
REQ-030 Without MULDIV_FAST_MUL_EN, MUL SHALL be an iterative shift-add lasting XLEN cycles, so out_valid rises after edge N+XLEN+1.
REQ-031 DIV timing SHALL be unaffected by the macro: out_valid rises after edge N+XLEN+1.

Structure
REQ-032 Package common SHALL hold the muldiv_op_t enum (the eight ops), the muldiv_state_t enum, and the constant MULDIV_FUNCT7 = 7'b0000001.
REQ-033 The divider datapath SHALL be a sub-module muldiv_div_core (start, dividend, divisor, quotient, remainder, done); the FSM and the multiplier stay in muldiv_unit.

Verification
REQ-034 DIV 100 / -7 (XLEN 32): result 0xFFFFFFF2 (-14), out_valid exactly 33 cycles after accept; REM on the same operands gives 2.
REQ-035 DIVU 5 / 0 gives 0xFFFFFFFF and REMU 5 / 0 gives 5, each after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 and REM on those operands gives 0.
REQ-036 MULH 0x80000000 x 0x80000000 gives 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE; both runs are checked with and without MULDIV_FAST_MUL_EN for the latency in REQ-029 and REQ-030.
REQ-037 funct7 = 0100000 with funct3 = 000 gives illegal 1 and result 0 after 1 cycle; out_ready held low for 5 cycles keeps out_valid and result stable with in_ready 0.
REQ-038 flush asserted 10 cycles into a DIV returns busy to 0 next cycle with no out_valid, and a simultaneous in_valid is not accepted; reset asserted mid-MUL clears all outputs at the next edge.
